paramest_nn_mul_pipe: RTL and testbench

//   Pipelined, multi-lane signed x unsigned multiplier for the ParamEst_NN datapath.
//   - Generalises the combinational mul_16s_15ns cores.
//   - Adds: configurable pipeline depth, valid/ready back-pressure, post-product shift with optional rounding.
//   - Sits between layer accumulators and weight ROM reads; one result per cycle when unstalled.

---
 rtl/paramest_nn_mul_pkg.sv | 27 ++
 rtl/paramest_nn_pipe_stage.sv | 36 +++
 rtl/paramest_nn_mul_pipe.sv | 100 ++++++++++
 tb/tb_paramest_nn_mul_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/paramest_nn_mul_pkg.sv
// Shared helpers for the ParamEst_NN pipelined multiplier: product width and saturating narrow.
// The clamp is only used when PARAMEST_MUL_SAT_EN is defined.
package paramest_nn_mul_pkg;

  localparam int unsigned DEFAULT_NUM_STAGE = 2;
  localparam int unsigned SAT_W = 64;

  function automatic int unsigned prod_w(input int unsigned a, input int unsigned b);
    return a + b + 1;
  endfunction

  // Returns {clamped, value} with value limited to the signed range of 'width' bits.
  function automatic logic [SAT_W:0] sat_narrow(input logic signed [SAT_W-1:0] value,
                                                input int unsigned width);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return {1'b1, hi};
    end else if (value < lo) begin
      return {1'b1, lo};
    end
    return {1'b0, value};
  endfunction

endpackage

// File: rtl/paramest_nn_pipe_stage.sv
// One valid/data slot of the multiplier pipeline with an asynchronous active-low clear.
module paramest_nn_pipe_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // An empty slot always takes a beat, so bubbles collapse.
  assign up_ready = !valid_q || dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (up_ready) begin
      valid_q <= up_valid;
      if (up_valid) begin
        data_q <= up_data;
      end
    end
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;

endmodule

// File: rtl/paramest_nn_mul_pipe.sv
// Pipelined multi-lane signed x unsigned multiplier with shift/round and valid/ready.
// Define PARAMEST_MUL_SAT_EN to clamp results to DOUT_WIDTH and report sat; otherwise results wrap.
module paramest_nn_mul_pipe
  import paramest_nn_mul_pkg::*;
#(
  parameter int unsigned LANES      = 1,
  parameter int unsigned DIN0_WIDTH = 16,
  parameter int unsigned DIN1_WIDTH = 15,
  parameter int unsigned DOUT_WIDTH = 31,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned ROUND_EN   = 0,
  parameter int unsigned NUM_STAGE  = DEFAULT_NUM_STAGE
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DIN0_WIDTH-1:0]   din0,
  input  logic [LANES*DIN1_WIDTH-1:0]   din1,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DOUT_WIDTH-1:0]   dout,
  output logic [LANES-1:0]              sat
);

  localparam int unsigned PW = prod_w(DIN0_WIDTH, DIN1_WIDTH);
  localparam int unsigned RW = LANES * DOUT_WIDTH;
  localparam int unsigned DW = RW + LANES;
  localparam int unsigned RoundSh = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [PW-1:0] RoundK =
      (ROUND_EN != 0 && SHIFT > 0) ? (PW'(1) << RoundSh) : '0;

  logic [RW-1:0]    res;
  logic [LANES-1:0] res_sat;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [PW-1:0]   a_ext;
    logic signed [PW-1:0]   b_ext;
    logic signed [PW-1:0]   p;
    logic signed [PW-1:0]   r;
    logic [DOUT_WIDTH-1:0]  lane_out;
    logic                   lane_sat;

    // din1 is unsigned: zero-extend so its MSB never reads as a sign bit.
    assign a_ext = PW'($signed(din0[l*DIN0_WIDTH +: DIN0_WIDTH]));
    assign b_ext = PW'({1'b0, din1[l*DIN1_WIDTH +: DIN1_WIDTH]});
    assign p     = a_ext * b_ext;
    assign r     = (p + RoundK) >>> SHIFT;

`ifdef PARAMEST_MUL_SAT_EN
    logic [SAT_W:0] nar;
    assign nar      = sat_narrow(SAT_W'(r), DOUT_WIDTH);
    assign lane_out = nar[DOUT_WIDTH-1:0];
    assign lane_sat = nar[SAT_W];
`else
    assign lane_out = DOUT_WIDTH'(r);
    assign lane_sat = 1'b0;
`endif

    assign res[l*DOUT_WIDTH +: DOUT_WIDTH] = lane_out;
    assign res_sat[l]                      = lane_sat;
  end

  logic [NUM_STAGE:0] vld;
  logic [DW-1:0]      dat [NUM_STAGE+1];

  assign vld[0] = in_valid;
  assign dat[0] = {res_sat, res};

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
    logic up_rdy;
    logic dn_rdy;

    // Ready ripples back from out_ready through each slot's valid bit.
    if (k == NUM_STAGE - 1) begin : g_last
      assign dn_rdy = out_ready;
    end else begin : g_mid
      assign dn_rdy = g_stage[k+1].up_rdy;
    end

    paramest_nn_pipe_stage #(
      .WIDTH (DW)
    ) u_stage (
      .clk      (ap_clk),
      .rst_n    (ap_rst_n),
      .up_valid (vld[k]),
      .up_ready (up_rdy),
      .up_data  (dat[k]),
      .dn_valid (vld[k+1]),
      .dn_ready (dn_rdy),
      .dn_data  (dat[k+1])
    );
  end

  assign in_ready  = g_stage[0].up_rdy;
  assign out_valid = vld[NUM_STAGE];
  assign dout      = dat[NUM_STAGE][RW-1:0];
  assign sat       = dat[NUM_STAGE][DW-1:RW];

endmodule

// File: tb/tb_paramest_nn_mul_pipe.sv
// Scoreboard bench for paramest_nn_mul_pipe across five parameter sets sharing clock and reset.
module tb_paramest_nn_mul_pipe;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int           id;
    logic [123:0] dout;
    logic [3:0]   sat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  logic [4:0] in_v = '0;
  logic [4:0] ordy = '1;
  logic [4:0] ir_g, ov_g;
  logic [123:0] dout_g [5];
  logic [3:0]   sat_g [5];

  // dut0 default, dut1 DOUT_WIDTH=16, dut2 SHIFT=4 rounding, dut3 SHIFT=4 truncating, dut4 LANES=4
  logic [15:0] d0_a = '0, d0_b = '0, d0_c = '0, d0_d = '0;
  logic [14:0] d1_a = '0, d1_b = '0, d1_c = '0, d1_d = '0;
  logic [63:0] d0_e = '0;
  logic [59:0] d1_e = '0;
  logic [30:0] dout_a, dout_c, dout_d;
  logic [15:0] dout_b;
  logic [123:0] dout_e;
  logic sat_a, sat_b, sat_c, sat_d;
  logic [3:0] sat_e;
  logic ir_a, ir_b, ir_c, ir_d, ir_e, ov_a, ov_b, ov_c, ov_d, ov_e;

  paramest_nn_mul_pipe u_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_v[0]), .in_ready(ir_a),
    .din0(d0_a), .din1(d1_a), .out_valid(ov_a), .out_ready(ordy[0]), .dout(dout_a), .sat(sat_a)
  );
  paramest_nn_mul_pipe #(.DOUT_WIDTH(16)) u_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_v[1]), .in_ready(ir_b),
    .din0(d0_b), .din1(d1_b), .out_valid(ov_b), .out_ready(ordy[1]), .dout(dout_b), .sat(sat_b)
  );
  paramest_nn_mul_pipe #(.SHIFT(4), .ROUND_EN(1)) u_c (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_v[2]), .in_ready(ir_c),
    .din0(d0_c), .din1(d1_c), .out_valid(ov_c), .out_ready(ordy[2]), .dout(dout_c), .sat(sat_c)
  );
  paramest_nn_mul_pipe #(.SHIFT(4), .ROUND_EN(0)) u_d (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_v[3]), .in_ready(ir_d),
    .din0(d0_d), .din1(d1_d), .out_valid(ov_d), .out_ready(ordy[3]), .dout(dout_d), .sat(sat_d)
  );
  paramest_nn_mul_pipe #(.LANES(4)) u_e (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_v[4]), .in_ready(ir_e),
    .din0(d0_e), .din1(d1_e), .out_valid(ov_e), .out_ready(ordy[4]), .dout(dout_e), .sat(sat_e)
  );

  assign ir_g = {ir_e, ir_d, ir_c, ir_b, ir_a};
  assign ov_g = {ov_e, ov_d, ov_c, ov_b, ov_a};
  assign dout_g[0] = 124'(dout_a);
  assign dout_g[1] = 124'(dout_b);
  assign dout_g[2] = 124'(dout_c);
  assign dout_g[3] = 124'(dout_d);
  assign dout_g[4] = dout_e;
  assign sat_g[0] = 4'(sat_a);
  assign sat_g[1] = 4'(sat_b);
  assign sat_g[2] = 4'(sat_c);
  assign sat_g[3] = 4'(sat_d);
  assign sat_g[4] = sat_e;

`ifdef PARAMEST_MUL_SAT_EN
  localparam logic [123:0] T3Pos = 124'h7FFF;
  localparam logic [3:0]   T3PosS = 4'd1;
  localparam logic [3:0]   T3NegS = 4'd1;
`else
  localparam logic [123:0] T3Pos = 124'h0001;
  localparam logic [3:0]   T3PosS = 4'd0;
  localparam logic [3:0]   T3NegS = 4'd0;
`endif

  localparam logic [63:0]  LaneA0 = {16'h8000, 16'h0100, 16'hFFFE, 16'h0003};
  localparam logic [59:0]  LaneA1 = {15'h7FFF, 15'h0100, 15'h0007, 15'h0005};
  localparam logic [123:0] LaneAR = {31'h40008000, 31'h00010000, 31'h7FFFFFF2, 31'h0000000F};
  localparam logic [63:0]  LaneB0 = {16'h0001, 16'h0001, 16'h0001, 16'h0001};
  localparam logic [59:0]  LaneB1 = {15'h0001, 15'h0001, 15'h0001, 15'h0001};
  localparam logic [123:0] LaneBR = {31'd1, 31'd1, 31'd1, 31'd1};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic [63:0] a, input logic [59:0] b);
    case (d)
      0: begin d0_a = a[15:0]; d1_a = b[14:0]; end
      1: begin d0_b = a[15:0]; d1_b = b[14:0]; end
      2: begin d0_c = a[15:0]; d1_c = b[14:0]; end
      3: begin d0_d = a[15:0]; d1_d = b[14:0]; end
      default: begin d0_e = a; d1_e = b; end
    endcase
    in_v[d] = 1'b1;
  endtask

  // Offers one beat, waits (bounded) for acceptance, queues the expected result.
  task automatic send(input int d, input logic [63:0] a, input logic [59:0] b,
                      input logic [123:0] ed, input logic [3:0] es, output int waits);
    exp_t e;
    drive(d, a, b);
    waits = 0;
    @(negedge ap_clk);
    while (!ir_g[d] && waits < 50) begin
      waits++;
      @(negedge ap_clk);
    end
    if (!ir_g[d]) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout dut%0d: in_ready stayed 0 for %0d cycles, required 1", d, waits);
    end else begin
      e.id = d;
      e.dout = ed;
      e.sat = es;
      sb.push_back(e);
    end
    @(posedge ap_clk);
    #1;
    in_v[d] = 1'b0;
  endtask

  task automatic flush(input int d);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].id == d) sb.delete(i);
    end
  endtask

  always @(negedge ap_clk) begin
    for (int d = 0; d < 5; d++) begin
      if (ov_g[d] && ordy[d]) begin
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (idx < 0 && sb[i].id == d) idx = i;
        end
        if (idx < 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out dut%0d: got dout=%h, required no output", d, dout_g[d]);
        end else begin
          chk($sformatf("dut%0d_dout", d), 128'(dout_g[d]), 128'(sb[idx].dout));
          chk($sformatf("dut%0d_sat", d), 128'(sat_g[d]), 128'(sb[idx].sat));
          sb.delete(idx);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("reset_out_valid", 128'(ov_g), 128'(0));
    chk("reset_dout", 128'(dout_g[4]), 128'(0));
    chk("reset_sat", 128'(sat_g[4]), 128'(0));
    chk("reset_in_ready", 128'(ir_g), 128'(5'b11111));
    @(posedge ap_clk);
    #1;

    // Latency of two with out_ready high
    send(0, 64'hFFFD, 60'h7FFF, 124'h7FFE8003, 4'd0, w);
    @(negedge ap_clk);
    chk("t1_not_yet_valid", 128'(ov_g[0]), 128'(0));
    @(negedge ap_clk);
    chk("t1_valid_at_latency", 128'(ov_g[0]), 128'(1));
    @(posedge ap_clk);
    #1;

    // din1 MSB set is still positive; then back-to-back throughput
    send(0, 64'h0002, 60'h4000, 124'h00008000, 4'd0, w);
    send(0, 64'h7FFF, 60'h7FFF, 124'h3FFF0001, 4'd0, w);
    chk("t2_tput_wait1", 128'(w), 128'(0));
    send(0, 64'hFFFF, 60'h0001, 124'h7FFFFFFF, 4'd0, w);
    chk("t2_tput_wait2", 128'(w), 128'(0));
    send(0, 64'h0000, 60'h7FFF, 124'h0, 4'd0, w);
    chk("t2_tput_wait3", 128'(w), 128'(0));
    repeat (4) @(posedge ap_clk);
    #1;

    // Narrow output: clamp or wrap depending on build
    send(1, 64'h7FFF, 60'h7FFF, T3Pos, T3PosS, w);
    send(1, 64'h8000, 60'h7FFF, 124'h8000, T3NegS, w);
    send(1, 64'h0100, 60'h007F, 124'h7F00, 4'd0, w);
    send(1, 64'hFFFF, 60'h0001, 124'hFFFF, 4'd0, w);

    // Shift by 4 with and without round-half-up
    send(2, 64'h0001, 60'h0008, 124'h1, 4'd0, w);
    send(2, 64'hFFFF, 60'h0008, 124'h0, 4'd0, w);
    send(3, 64'h0001, 60'h0008, 124'h0, 4'd0, w);
    send(3, 64'hFFFF, 60'h0008, 124'h7FFFFFFF, 4'd0, w);
    repeat (4) @(posedge ap_clk);
    #1;

    // Back-pressure: A and B fill the pipe, C is held off, A stays on the output
    ordy[0] = 1'b0;
    send(0, 64'h0003, 60'h0005, 124'h0F, 4'd0, w);
    send(0, 64'hFFFE, 60'h0007, 124'h7FFFFFF2, 4'd0, w);
    drive(0, 64'h0100, 60'h0100);
    for (int i = 0; i < 2; i++) begin
      @(negedge ap_clk);
      chk("t5_c_blocked", 128'(ir_g[0]), 128'(0));
      chk("t5_hold_valid", 128'(ov_g[0]), 128'(1));
      chk("t5_hold_dout", 128'(dout_g[0]), 128'(124'h0F));
    end
    @(posedge ap_clk);
    #1;
    ordy[0] = 1'b1;
    send(0, 64'h0100, 60'h0100, 124'h10000, 4'd0, w);
    chk("t5_accept_on_drain", 128'(w), 128'(0));
    @(negedge ap_clk);
    chk("t5_stream_b", 128'(ov_g[0]), 128'(1));
    @(negedge ap_clk);
    chk("t5_stream_c", 128'(ov_g[0]), 128'(1));
    repeat (3) @(posedge ap_clk);
    #1;

    // Mid-cycle reset with two beats in flight on the 4-lane instance
    send(4, LaneA0, LaneA1, LaneAR, 4'd0, w);
    send(4, LaneB0, LaneB1, LaneBR, 4'd0, w);
    #1 ap_rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 128'(ov_g[4]), 128'(0));
    chk("t6_rst_dout", 128'(dout_g[4]), 128'(0));
    flush(4);
    #1 ap_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      chk("t6_quiet", 128'(ov_g[4]), 128'(0));
    end
    @(posedge ap_clk);
    #1;
    send(4, LaneA0, LaneA1, LaneAR, 4'd0, w);
    @(negedge ap_clk);
    chk("t6_not_yet_valid", 128'(ov_g[4]), 128'(0));
    @(negedge ap_clk);
    chk("t6_valid_at_latency", 128'(ov_g[4]), 128'(1));

    repeat (5) @(posedge ap_clk);
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
